debug_display_ctrl: RTL and testbench
=====================================

DEBUG_DISPLAY_CTRL -- requirements
Module: debug_display_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 8: number of debug channels, 2..32.
REQ-002 The block SHALL have parameter W, default 16: channel width in bits, 4..64.
REQ-003 The block SHALL have parameter DEBOUNCE_CYC, default 500000: stable cycles required before a key level is accepted, >=2.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port KeyStep_n, input, 1 bit: raw active-low step button, asynchronous to Clk.
REQ-007 The block SHALL have port KeyHold_n, input, 1 bit: raw active-low freeze button, asynchronous to Clk.
REQ-008 The block SHALL have port ChanData, input, N_CH*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-009 The block SHALL have port ChanIdx, output, CW=max(1,$clog2(N_CH)) bits: currently selected channel.
REQ-010 The block SHALL have port Value, output, W bits: registered displayed value.
REQ-011 The block SHALL have port Frozen, output, 1 bit: high while the display is held.
REQ-012 The block SHALL have port Strobe, output, 1 bit: one-cycle pulse on each accepted ChanIdx change.

Function
REQ-013 Each key SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Each key SHALL have its own debounce counter; the counter SHALL clear whenever the synchronised level differs from the filtered level.
REQ-015 The filtered level SHALL take the synchronised level once the mismatch has persisted DEBOUNCE_CYC consecutive cycles.
REQ-016 A press event SHALL be a one-cycle pulse on a filtered 1->0 transition; releases SHALL generate no event.
REQ-017 A hold press SHALL toggle Frozen in the cycle after the press event.
REQ-018 A step press with Frozen low, as sampled before that edge, SHALL advance ChanIdx by 1, wrapping from N_CH-1 to 0 for any N_CH including non-powers of 2, and SHALL pulse Strobe in the same cycle ChanIdx changes.
REQ-019 A step press while Frozen is high SHALL be discarded: no ChanIdx change and no Strobe.
REQ-020 When step and hold events occur in the same cycle, step SHALL use the pre-edge Frozen value and the toggle SHALL still apply.
REQ-021 With Frozen low, Value SHALL load ChanData[ChanIdx] every cycle, giving 1-cycle latency from ChanData or ChanIdx change to Value.
REQ-022 With Frozen high, Value SHALL hold its last loaded value regardless of ChanData.
REQ-023 Keys held continuously SHALL produce exactly one event per press; there SHALL be no auto-repeat.

Reset
REQ-024 Reset low SHALL asynchronously force: ChanIdx=0, Value=0, Frozen=0, Strobe=0, synchroniser flops=1, filtered levels=1 (released), debounce counters=0, and scan counter=0 when present.
REQ-025 Reset asserted mid-debounce or mid-scan SHALL discard the partial count; no event SHALL fire on reset release while the keys are released.

Configuration
REQ-026 With macro DBG_AUTOSCAN_EN defined, the block SHALL add parameter SCAN_CYC (default 50000000) and input port ScanEn (1 bit).
REQ-027 With DBG_AUTOSCAN_EN, while ScanEn=1 and Frozen=0, the scan counter SHALL count to SCAN_CYC-1, then advance ChanIdx with wrap, pulse Strobe, and restart from 0.
REQ-028 With DBG_AUTOSCAN_EN, a manual step or ScanEn=0 SHALL clear the scan counter, and an advance coinciding with a manual step SHALL advance ChanIdx only once.
REQ-029 Without DBG_AUTOSCAN_EN, the block SHALL contain no SCAN_CYC parameter, ScanEn port or scan counter, and behaviour SHALL be exactly REQ-013..REQ-025.

Verification (N_CH=5, W=16, DEBOUNCE_CYC=4)
REQ-030 The bench SHALL cover: KeyStep_n low for 3 cycles then high -> no Strobe and ChanIdx stays 0; low for 10 cycles -> exactly one Strobe and ChanIdx=1.
REQ-031 The bench SHALL cover: 5 clean step presses from reset -> ChanIdx sequence 1,2,3,4,0 with 5 Strobes.
REQ-032 The bench SHALL cover: ChanData channel 2 = 16'hBEEF, ChanIdx=2 -> Value=16'hBEEF one cycle later; hold press, then channel 2 = 16'h1234 -> Value stays 16'hBEEF and Frozen=1.
REQ-033 The bench SHALL cover: while Frozen=1, step press -> ChanIdx unchanged and no Strobe; second hold press -> Frozen=0 and Value tracks the live channel 2 value next cycle.
REQ-034 The bench SHALL cover: Reset pulsed low while ChanIdx=3, Frozen=1, and a step press is mid-debounce -> all outputs 0 immediately, and no Strobe after release.
REQ-035 The bench SHALL cover, with DBG_AUTOSCAN_EN, SCAN_CYC=8, ScanEn=1: ChanIdx advances every 8 cycles, and a manual step at cycle 5 gives a single advance and restarts the 8-cycle interval.

Source files
------------

// File: rtl/debug_display_ctrl.sv
// debug_display_ctrl: debounced step/freeze keys select one of N_CH channels shown on Value.
// Defining DBG_AUTOSCAN_EN adds SCAN_CYC and ScanEn for timed channel cycling.
module debug_display_ctrl #(
    parameter int N_CH         = 8,
    parameter int W            = 16,
    parameter int DEBOUNCE_CYC = 500000
`ifdef DBG_AUTOSCAN_EN
    ,
    parameter int SCAN_CYC     = 50000000
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      KeyStep_n,
    input  logic                      KeyHold_n,
`ifdef DBG_AUTOSCAN_EN
    input  logic                      ScanEn,
`endif
    input  logic [N_CH*W-1:0]         ChanData,
    output logic [$clog2(N_CH)-1:0]   ChanIdx,
    output logic [W-1:0]              Value,
    output logic                      Frozen,
    output logic                      Strobe
);
    localparam int CW = $clog2(N_CH);
    localparam int DW = $clog2(DEBOUNCE_CYC);

    logic [1:0]    w_key;
    logic [1:0]    r_s1, r_s2, r_filt, r_ev;
    logic [DW-1:0] r_cnt [2];
    logic [CW-1:0] r_idx;
    logic [W-1:0]  r_val;
    logic          r_frozen, r_strobe;
    logic          w_step, w_scan, w_adv;
    logic [W-1:0]  w_ch [N_CH];

    assign w_key = {KeyHold_n, KeyStep_n};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_ch[c] = ChanData[c*W +: W];
    end

    // index 0 is the step key, index 1 the hold key; r_ev pulses on a filtered 1->0 only
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_s1   <= '1;
            r_s2   <= '1;
            r_filt <= '1;
            r_ev   <= '0;
            r_cnt  <= '{default: '0};
        end else begin
            r_s1 <= w_key;
            r_s2 <= r_s1;
            for (int k = 0; k < 2; k++) begin
                r_ev[k] <= 1'b0;
                if (r_s2[k] == r_filt[k])
                    r_cnt[k] <= '0;
                else if (r_cnt[k] == DW'(DEBOUNCE_CYC - 1)) begin
                    r_cnt[k]  <= '0;
                    r_filt[k] <= r_s2[k];
                    r_ev[k]   <= r_filt[k];
                end else
                    r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    assign w_step = r_ev[0] && !r_frozen;
    assign w_adv  = w_step || w_scan;

`ifdef DBG_AUTOSCAN_EN
    localparam int SW = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;
    logic [SW-1:0] r_scan;

    assign w_scan = ScanEn && !r_frozen && r_scan == SW'(SCAN_CYC - 1);

    // the counter pauses while frozen and restarts on any manual step
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_scan <= '0;
        else if (!ScanEn || w_step)
            r_scan <= '0;
        else if (!r_frozen)
            r_scan <= w_scan ? '0 : r_scan + 1'b1;
    end
`else
    assign w_scan = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_idx    <= '0;
            r_val    <= '0;
            r_frozen <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_frozen <= r_frozen ^ r_ev[1];
            r_strobe <= w_adv;
            if (w_adv)
                r_idx <= (r_idx == CW'(N_CH - 1)) ? '0 : r_idx + 1'b1;
            if (!r_frozen)
                r_val <= w_ch[r_idx];
        end
    end

    assign ChanIdx = r_idx;
    assign Value   = r_val;
    assign Frozen  = r_frozen;
    assign Strobe  = r_strobe;
endmodule

// File: tb/tb_debug_display_ctrl.sv
// tb_debug_display_ctrl: directed stimulus, per-cycle model comparison and literal checks.
module tb_debug_display_ctrl;
    localparam int N_CH = 5;
    localparam int W    = 16;
    localparam int DEB  = 4;
    localparam int SCAN = 8;

    logic          Clk = 0;
    logic          Reset = 1;
    logic          KeyStep_n = 1;
    logic          KeyHold_n = 1;
    logic [N_CH*W-1:0] ChanData;
    logic [2:0]    ChanIdx;
    logic [W-1:0]  Value;
    logic          Frozen, Strobe;
`ifdef DBG_AUTOSCAN_EN
    logic          scan_en = 0;
`endif

    int vectors = 0;
    int errors = 0;
    int stb_cnt = 0;

    debug_display_ctrl #(
        .N_CH(N_CH), .W(W), .DEBOUNCE_CYC(DEB)
`ifdef DBG_AUTOSCAN_EN
        , .SCAN_CYC(SCAN)
`endif
    ) dut (
        .Clk(Clk), .Reset(Reset), .KeyStep_n(KeyStep_n), .KeyHold_n(KeyHold_n),
`ifdef DBG_AUTOSCAN_EN
        .ScanEn(scan_en),
`endif
        .ChanData(ChanData), .ChanIdx(ChanIdx), .Value(Value), .Frozen(Frozen), .Strobe(Strobe)
    );

    always #5 Clk = ~Clk;

    // model: a key press is a run of DEB consecutive seen-low samples, seen two clocks late;
    // the resulting action lands one clock after the press is recognised
    int       m_idx = 0;
    logic [W-1:0] m_val = '0;
    bit       m_frz = 0, m_stb = 0;
    bit       m_lvl [2] = '{1, 1};
    bit       m_pend [2] = '{0, 0};
    int       m_run [2] = '{0, 0};
    bit       m_late [2][2] = '{'{1, 1}, '{1, 1}};
    int       m_sc = 0;
    bit       go, adv, seen, raw;

    function automatic logic [W-1:0] ch(int i);
        return ChanData[i*W +: W];
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_idx = 0; m_val = '0; m_frz = 0; m_stb = 0; m_sc = 0;
            m_lvl = '{1, 1}; m_pend = '{0, 0}; m_run = '{0, 0};
            m_late = '{'{1, 1}, '{1, 1}};
        end else begin
            go = m_pend[0] && !m_frz;
            adv = go;
`ifdef DBG_AUTOSCAN_EN
            if (!scan_en || go) m_sc = 0;
            else if (!m_frz) begin
                if (m_sc == SCAN - 1) begin adv = 1; m_sc = 0; end
                else m_sc++;
            end
`endif
            if (!m_frz) m_val = ch(m_idx);
            if (adv) m_idx = (m_idx + 1) % N_CH;
            m_stb = adv;
            m_frz = m_frz ^ m_pend[1];
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? KeyStep_n : KeyHold_n;
                seen = m_late[k][1];
                m_late[k][1] = m_late[k][0];
                m_late[k][0] = raw;
                m_pend[k] = 0;
                if (seen != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_pend[k] = m_lvl[k] && !seen;
                        m_lvl[k] = seen;
                        m_run[k] = 0;
                    end
                end else m_run[k] = 0;
            end
        end
    end

    always @(negedge Clk) begin
        vectors++;
        if (ChanIdx !== 3'(m_idx) || Value !== m_val || Frozen !== m_frz || Strobe !== m_stb) begin
            errors++;
            $display("FAIL model t=%0t idx %0d want %0d, value %h want %h, frozen %b want %b, strobe %b want %b",
                     $time, ChanIdx, m_idx, Value, m_val, Frozen, m_frz, Strobe, m_stb);
        end
        if (Strobe === 1'b1) stb_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic press(input bit hold, input int n);
        if (hold) KeyHold_n = 0; else KeyStep_n = 0;
        tick(n);
        KeyStep_n = 1;
        KeyHold_n = 1;
        tick(12);
    endtask

    task automatic do_reset();
        Reset = 0;
        tick(3);
        Reset = 1;
        stb_cnt = 0;
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) ChanData[i*W +: W] = 16'hA000 + 16'(i);
        #1 Reset = 0;
        tick(3);
        chk("reset_idx", 32'(ChanIdx), 0);
        chk("reset_value", 32'(Value), 0);
        chk("reset_frozen", 32'(Frozen), 0);
        chk("reset_strobe", 32'(Strobe), 0);
        Reset = 1;
        stb_cnt = 0;
        tick(4);

        press(0, 3);
        chk("short_idx", 32'(ChanIdx), 0);
        chk("short_strobes", 32'(stb_cnt), 0);
        press(0, 10);
        chk("long_idx", 32'(ChanIdx), 1);
        chk("long_strobes", 32'(stb_cnt), 1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(0, (i == 2) ? 40 : 10);
            chk("seq_idx", 32'(ChanIdx), 32'((i + 1) % 5));
        end
        chk("seq_strobes", 32'(stb_cnt), 5);

        press(0, 10);
        press(0, 10);
        chk("at_ch2", 32'(ChanIdx), 2);
        ChanData[2*W +: W] = 16'hBEEF;
        tick(1);
        chk("value_beef", 32'(Value), 32'h0000BEEF);
        press(1, 10);
        ChanData[2*W +: W] = 16'h1234;
        tick(3);
        chk("frozen_value", 32'(Value), 32'h0000BEEF);
        chk("frozen_flag", 32'(Frozen), 1);

        stb_cnt = 0;
        press(0, 10);
        chk("frz_step_idx", 32'(ChanIdx), 2);
        chk("frz_step_strobes", 32'(stb_cnt), 0);
        press(1, 10);
        chk("unfrozen", 32'(Frozen), 0);
        chk("live_value", 32'(Value), 32'h00001234);
        ChanData[2*W +: W] = 16'h5678;
        tick(1);
        chk("track_value", 32'(Value), 32'h00005678);

        press(0, 10);
        press(1, 10);
        chk("pre_rst_idx", 32'(ChanIdx), 3);
        chk("pre_rst_frozen", 32'(Frozen), 1);
        KeyStep_n = 0;
        tick(3);
        Reset = 0;
        #1;
        chk("mid_rst_idx", 32'(ChanIdx), 0);
        chk("mid_rst_value", 32'(Value), 0);
        chk("mid_rst_frozen", 32'(Frozen), 0);
        chk("mid_rst_strobe", 32'(Strobe), 0);
        tick(1);
        KeyStep_n = 1;
        tick(1);
        Reset = 1;
        stb_cnt = 0;
        tick(15);
        chk("post_rst_strobes", 32'(stb_cnt), 0);
        chk("post_rst_idx", 32'(ChanIdx), 0);

`ifdef DBG_AUTOSCAN_EN
        Reset = 0;
        scan_en = 1;
        tick(3);
        Reset = 1;
        tick(8);
        chk("scan_1", 32'(ChanIdx), 1);
        tick(8);
        chk("scan_2", 32'(ChanIdx), 2);
        KeyStep_n = 0;
        tick(7);
        chk("scan_manual", 32'(ChanIdx), 3);
        KeyStep_n = 1;
        tick(7);
        chk("scan_restart_hold", 32'(ChanIdx), 3);
        tick(1);
        chk("scan_restart_adv", 32'(ChanIdx), 4);
        tick(8);
        chk("scan_wrap", 32'(ChanIdx), 0);
        scan_en = 0;
        tick(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
